pt_add_ld_seq: RTL and testbench

Parametrised, multi-cycle López-Dahab point adder over GF(2^M), the sequential successor to the combinational 4-bit LD adder. It time-multiplexes one GF(2^M) multiplier and one XOR adder under a step-counter FSM. It computes (X2,Y2,Z2) = P0 + P1 from two projective inputs. It sits between the scalar-multiplication controller and the coordinate register file, and uses a start/done handshake.

---
 rtl/pt_add_ld_seq.sv | 232 +++++++++++++++++++++++
 tb/tb_pt_add_ld_seq.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pt_add_ld_seq.sv
`default_nettype none
// ============================================================================
// Module   : pt_add_ld_seq
// Purpose  : Multi-cycle Lopez-Dahab projective point adder over GF(2^M).
//            One GF(2^M) multiplier and one XOR adder are time-shared across
//            a fixed 20-step schedule to compute (X2,Y2,Z2) = P0 + P1.
//
// Ports    : clk            rising-edge clock
//            rst            synchronous active-high reset
//            start          request, sampled only while ready=1
//            ready          high while idle
//            done           one-cycle pulse when X2/Y2/Z2 are updated
//            X0,Y0,Z0       point P0 (projective)
//            X1,Y1,Z1       point P1 (projective)
//            X2,Y2,Z2       registered result, held until the next done
//
// Options  : PTADD_INF_CHECK_EN - when defined, a request whose Z0 or Z1 is
//            zero bypasses the schedule and returns the other point
//            (P1 if Z0=0, else P0) with done one cycle after accept.
//
// Revision : 1.0  initial release
// ============================================================================
module pt_add_ld_seq #(
  parameter int           M      = 4,
  parameter logic [M:0]   POLY   = 5'b10011,
  parameter logic [M-1:0] A_COEF = 4'b0100
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         ready,
  output logic         done,
  input  logic [M-1:0] X0,
  input  logic [M-1:0] Y0,
  input  logic [M-1:0] Z0,
  input  logic [M-1:0] X1,
  input  logic [M-1:0] Y1,
  input  logic [M-1:0] Z1,
  output logic [M-1:0] X2,
  output logic [M-1:0] Y2,
  output logic [M-1:0] Z2
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [4:0] LAST_STEP = 5'd19;
  // Step 19's product (y1) is consumed directly, so only 19 slots are kept.
  localparam int         NSCR      = 19;

  // Scratch slot of each intermediate; slot index equals the step producing it.
  localparam int SC_A0S = 0;   // Z0^2
  localparam int SC_A0  = 1;   // Y1*Z0^2
  localparam int SC_A1S = 2;   // Z1^2
  localparam int SC_A1  = 3;   // Y0*Z1^2
  localparam int SC_B0  = 4;   // X1*Z0
  localparam int SC_B1  = 5;   // X0*Z1
  localparam int SC_E   = 6;   // Z0*Z1
  localparam int SC_F   = 7;   // D*E
  localparam int SC_Z2  = 8;   // F^2
  localparam int SC_G0  = 9;   // D^2
  localparam int SC_G1  = 10;  // E^2
  localparam int SC_G2  = 11;  // a*E^2
  localparam int SC_G   = 12;  // D^2*(F+aE^2)
  localparam int SC_H   = 13;  // C*F
  localparam int SC_C0  = 14;  // C^2
  localparam int SC_I1  = 15;  // D^2*B0
  localparam int SC_I2  = 16;  // D^2*B0*E
  localparam int SC_J0  = 17;  // D^2*A0
  localparam int SC_Y0  = 18;  // H*(I+X2)

  state_e       state_q, state_d;
  logic [4:0]   s_q, s_d;
  logic [M-1:0] x0_q, y0_q, z0_q, x1_q, y1_q, z1_q;
  logic [M-1:0] sc_q [NSCR];
  logic [M-1:0] x2_q, y2_q, z2_q;
  logic [M-1:0] x2_d, y2_d, z2_d;

  logic         w_cap;
  logic         w_step;
  logic [M-1:0] w_op_a, w_op_b, w_mul;
  logic [M-1:0] w_d_sum, w_c_sum, w_x2;

  // Shift-and-add GF(2^M) multiply, MSB first, reducing after every shift.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a,
                                          input logic [M-1:0] b);
    logic [M-1:0] acc;
    acc = '0;
    for (int i = M - 1; i >= 0; i--) begin
      acc = {acc[M-2:0], 1'b0} ^ (acc[M-1] ? POLY[M-1:0] : '0);
      if (b[i]) acc = acc ^ a;
    end
    return acc;
  endfunction

  // Additions folded into the operand paths.
  assign w_d_sum = sc_q[SC_B0] ^ sc_q[SC_B1];
  assign w_c_sum = sc_q[SC_A0] ^ sc_q[SC_A1];
  assign w_x2    = sc_q[SC_C0] ^ sc_q[SC_H] ^ sc_q[SC_G];

  // Operand selection per schedule step.
  always_comb begin
    w_op_a = '0;
    w_op_b = '0;
    case (s_q)
      5'd0:  begin w_op_a = z0_q;          w_op_b = z0_q;                         end
      5'd1:  begin w_op_a = y1_q;          w_op_b = sc_q[SC_A0S];                 end
      5'd2:  begin w_op_a = z1_q;          w_op_b = z1_q;                         end
      5'd3:  begin w_op_a = y0_q;          w_op_b = sc_q[SC_A1S];                 end
      5'd4:  begin w_op_a = x1_q;          w_op_b = z0_q;                         end
      5'd5:  begin w_op_a = x0_q;          w_op_b = z1_q;                         end
      5'd6:  begin w_op_a = z0_q;          w_op_b = z1_q;                         end
      5'd7:  begin w_op_a = w_d_sum;       w_op_b = sc_q[SC_E];                   end
      5'd8:  begin w_op_a = sc_q[SC_F];    w_op_b = sc_q[SC_F];                   end
      5'd9:  begin w_op_a = w_d_sum;       w_op_b = w_d_sum;                      end
      5'd10: begin w_op_a = sc_q[SC_E];    w_op_b = sc_q[SC_E];                   end
      5'd11: begin w_op_a = A_COEF;        w_op_b = sc_q[SC_G1];                  end
      5'd12: begin w_op_a = sc_q[SC_G0];   w_op_b = sc_q[SC_F] ^ sc_q[SC_G2];     end
      5'd13: begin w_op_a = w_c_sum;       w_op_b = sc_q[SC_F];                   end
      5'd14: begin w_op_a = w_c_sum;       w_op_b = w_c_sum;                      end
      5'd15: begin w_op_a = sc_q[SC_G0];   w_op_b = sc_q[SC_B0];                  end
      5'd16: begin w_op_a = sc_q[SC_I1];   w_op_b = sc_q[SC_E];                   end
      5'd17: begin w_op_a = sc_q[SC_G0];   w_op_b = sc_q[SC_A0];                  end
      5'd18: begin w_op_a = sc_q[SC_H];    w_op_b = sc_q[SC_I2] ^ w_x2;           end
      5'd19: begin w_op_a = sc_q[SC_Z2];   w_op_b = sc_q[SC_J0] ^ w_x2;           end
      default: ;
    endcase
  end

  assign w_mul = gf_mul(w_op_a, w_op_b);

  // Next-state and output-register load logic.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    w_cap   = 1'b0;
    w_step  = 1'b0;
    x2_d    = x2_q;
    y2_d    = y2_q;
    z2_d    = z2_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          w_cap   = 1'b1;
          s_d     = '0;
          state_d = ST_CALC;
`ifdef PTADD_INF_CHECK_EN
          // A point at infinity (Z=0) contributes nothing: return the other.
          if (Z0 == '0) begin
            state_d = ST_DONE;
            x2_d    = X1;
            y2_d    = Y1;
            z2_d    = Z1;
          end else if (Z1 == '0) begin
            state_d = ST_DONE;
            x2_d    = X0;
            y2_d    = Y0;
            z2_d    = Z0;
          end
`endif
        end
      end
      ST_CALC: begin
        w_step = 1'b1;
        if (s_q == LAST_STEP) begin
          // The final product y1 is folded into Y2 on the same edge that
          // raises done, so the result and the pulse line up.
          state_d = ST_DONE;
          s_d     = '0;
          x2_d    = w_x2;
          y2_d    = sc_q[SC_Y0] ^ w_mul;
          z2_d    = sc_q[SC_Z2];
        end else begin
          s_d = s_q + 5'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      x2_q    <= '0;
      y2_q    <= '0;
      z2_q    <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      z0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      z1_q    <= '0;
      for (int i = 0; i < NSCR; i++) begin
        sc_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      x2_q    <= x2_d;
      y2_q    <= y2_d;
      z2_q    <= z2_d;
      if (w_cap) begin
        x0_q <= X0;
        y0_q <= Y0;
        z0_q <= Z0;
        x1_q <= X1;
        y1_q <= Y1;
        z1_q <= Z1;
      end
      if (w_step && (s_q != LAST_STEP)) begin
        sc_q[s_q] <= w_mul;
      end
    end
  end

  assign ready = (state_q == ST_IDLE);
  assign done  = (state_q == ST_DONE);
  assign X2    = x2_q;
  assign Y2    = y2_q;
  assign Z2    = z2_q;

endmodule
`default_nettype wire

// File: tb/tb_pt_add_ld_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_pt_add_ld_seq
// Purpose  : Self-checking bench for pt_add_ld_seq (M=4, x^4+x+1, a=4).
//            Stimulus pushes expected results into a queue; a monitor pops
//            and compares whenever done is seen, and also checks ready,
//            latency and that outputs hold between results.
// Revision : 1.0  initial release
// ============================================================================
module tb_pt_add_ld_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       ready, done;
  logic [3:0] X0 = '0, Y0 = '0, Z0 = '0, X1 = '0, Y1 = '0, Z1 = '0;
  logic [3:0] X2, Y2, Z2;

  pt_add_ld_seq #(
    .M      (4),
    .POLY   (5'b10011),
    .A_COEF (4'b0100)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .ready (ready),
    .done  (done),
    .X0    (X0),
    .Y0    (Y0),
    .Z0    (Z0),
    .X1    (X1),
    .Y1    (Y1),
    .Z1    (Z1),
    .X2    (X2),
    .Y2    (Y2),
    .Z2    (Z2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] z;
    int         acc;
    int         lat;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  int         done_cnt = 0;
  int         last_acc = 0;
  logic [3:0] hx = '0, hy = '0, hz = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: full carry-less product, then polynomial long division.
  function automatic logic [3:0] fm(input logic [3:0] a, input logic [3:0] b);
    logic [6:0] p;
    logic [6:0] pl;
    p  = '0;
    pl = 7'b0010011;
    for (int i = 0; i < 4; i++)
      if (b[i]) p = p ^ ({3'b000, a} << i);
    for (int d = 6; d >= 4; d--)
      if (p[d]) p = p ^ (pl << (d - 4));
    return p[3:0];
  endfunction

  function automatic exp_t mk(input logic [3:0] x, input logic [3:0] y,
                              input logic [3:0] z, input int lat);
    exp_t e;
    e.x = x; e.y = y; e.z = z; e.acc = 0; e.lat = lat;
    return e;
  endfunction

  function automatic exp_t model(input logic [3:0] x0, input logic [3:0] y0,
                                 input logic [3:0] z0, input logic [3:0] x1,
                                 input logic [3:0] y1, input logic [3:0] z1);
    logic [3:0] a0, a1, b0, b1, c, d, e, f, z, d2, g, h, x, i, j, y;
`ifdef PTADD_INF_CHECK_EN
    if (z0 == 4'd0) return mk(x1, y1, z1, 0);
    if (z1 == 4'd0) return mk(x0, y0, z0, 0);
`endif
    a0 = fm(y1, fm(z0, z0));
    a1 = fm(y0, fm(z1, z1));
    b0 = fm(x1, z0);
    b1 = fm(x0, z1);
    c  = a0 ^ a1;
    d  = b0 ^ b1;
    e  = fm(z0, z1);
    f  = fm(d, e);
    z  = fm(f, f);
    d2 = fm(d, d);
    g  = fm(d2, f ^ fm(4'h4, fm(e, e)));
    h  = fm(c, f);
    x  = fm(c, c) ^ h ^ g;
    i  = fm(fm(d2, b0), e);
    j  = fm(d2, a0);
    y  = fm(h, i ^ x) ^ fm(z, j ^ x);
    return mk(x, y, z, 20);
  endfunction

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    logic exp_ready;
    #1;
    if (done) begin
      done_cnt++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending request (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        chk("X2", X2, e.x);
        chk("Y2", Y2, e.y);
        chk("Z2", Z2, e.z);
        chk("latency", cyc - e.acc, e.lat);
        hx = e.x; hy = e.y; hz = e.z;
      end
    end else begin
      chk("hold_X2", X2, hx);
      chk("hold_Y2", Y2, hy);
      chk("hold_Z2", Z2, hz);
      if (q.size() > 0 && cyc > q[0].acc + q[0].lat + 3) begin
        checks++;
        errors++;
        $display("FAIL done_timeout: got no done expected one by cycle %0d", q[0].acc + q[0].lat);
        void'(q.pop_front());
      end
    end
    exp_ready = !done && !(q.size() > 0 && cyc >= q[0].acc);
    chk("ready", ready, exp_ready);
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got ready=0 expected 1 within 60 cycles");
    end
  endtask

  task automatic issue(input logic [3:0] a0, input logic [3:0] b0, input logic [3:0] c0,
                       input logic [3:0] a1, input logic [3:0] b1, input logic [3:0] c1,
                       input exp_t e_in);
    exp_t e;
    wait_ready();
    X0 = a0; Y0 = b0; Z0 = c0; X1 = a1; Y1 = b1; Z1 = c1;
    start = 1'b1;
    e = e_in;
    e.acc = cyc + 1;
    last_acc = e.acc;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    X0 = 4'($urandom); Y0 = 4'($urandom); Z0 = 4'($urandom);
    X1 = 4'($urandom); Y1 = 4'($urandom); Z1 = 4'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    exp_t       e;
    int         k;
    int         dc;
    logic [3:0] r [6];

    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Basic addition from the reference vector.
    issue(4'd1, 4'd0, 4'd1, 4'd0, 4'd1, 4'd1, mk(4'd5, 4'd1, 4'd1, 20));
    // Doubling through the add formulas collapses to zero.
    issue(4'd3, 4'd5, 4'd1, 4'd3, 4'd5, 4'd1, mk(4'd0, 4'd0, 4'd0, 20));
    // P0 at infinity.
`ifdef PTADD_INF_CHECK_EN
    issue(4'd0, 4'd0, 4'd0, 4'd3, 4'd5, 4'd1, mk(4'd3, 4'd5, 4'd1, 0));
`else
    issue(4'd0, 4'd0, 4'd0, 4'd3, 4'd5, 4'd1, mk(4'd0, 4'd0, 4'd0, 20));
`endif
    drain();

    // Start while busy must be ignored.
    issue(4'd1, 4'd0, 4'd1, 4'd0, 4'd1, 4'd1, mk(4'd5, 4'd1, 4'd1, 20));
    while (cyc < last_acc + 7) @(negedge clk);
    X0 = 4'd7; Y0 = 4'd2; Z0 = 4'd3; X1 = 4'd9; Y1 = 4'd4; Z1 = 4'd6;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Reset in the middle of a computation.
    issue(4'd1, 4'd0, 4'd1, 4'd0, 4'd1, 4'd1, mk(4'd5, 4'd1, 4'd1, 20));
    while (cyc < last_acc + 10) @(negedge clk);
    rst = 1'b1;
    q.delete();
    hx = '0; hy = '0; hz = '0;
    @(negedge clk);
    rst = 1'b0;
    issue(4'd1, 4'd0, 4'd1, 4'd0, 4'd1, 4'd1, mk(4'd5, 4'd1, 4'd1, 20));
    drain();

    // Back-to-back: start held high across the ready-return cycle.
    wait_ready();
    dc = done_cnt;
    X0 = 4'd1; Y0 = 4'd0; Z0 = 4'd1; X1 = 4'd0; Y1 = 4'd1; Z1 = 4'd1;
    start = 1'b1;
    e = mk(4'd5, 4'd1, 4'd1, 20);
    e.acc = cyc + 1;
    k = e.acc;
    q.push_back(e);
    @(negedge clk);
    X0 = 4'd2; Y0 = 4'd7; Z0 = 4'd3; X1 = 4'd9; Y1 = 4'd4; Z1 = 4'd5;
    e = model(4'd2, 4'd7, 4'd3, 4'd9, 4'd4, 4'd5);
    e.acc = k + 22;
    q.push_back(e);
    while (cyc < k + 22) @(negedge clk);
    start = 1'b0;
    drain();
    chk("b2b_done_count", done_cnt - dc, 2);

    // Randomized requests against the reference model.
    for (int t = 0; t < 40; t++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      for (int i = 0; i < 6; i++) r[i] = 4'($urandom);
      if ($urandom_range(0, 5) == 0) r[2] = 4'd0;
      if ($urandom_range(0, 5) == 0) r[5] = 4'd0;
      issue(r[0], r[1], r[2], r[3], r[4], r[5],
            model(r[0], r[1], r[2], r[3], r[4], r[5]));
    end
    drain();
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
